// File: rtl/keypad_pkg.sv
// Shared types and helper functions for the debounced keypad encoder.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PRESS,
        HOLD,
        RELEASE
    } state_t;

    // Widest keypad the helper functions accept; callers zero-extend into this.
    localparam int unsigned MAX_KEYS = 64;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Highest set index among the first n bits; 0 when nothing is set.
    function automatic int unsigned prio_encode(input logic [MAX_KEYS-1:0] v,
                                                input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAX_KEYS; i++) begin
            if (i < n && v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [MAX_KEYS-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_KEYS; i++) begin
            if (v[i]) begin
                c = c + 1;
            end
        end
        return (c > 1);
    endfunction

endpackage

// File: rtl/keypad_encoder_db_sync2.sv
// Per-bit two-flop synchroniser with asynchronous active-low reset.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back stages; only q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder_db.sv
// Synchronised, debounced, priority-encoded keypad with load strobe and
// optional auto-repeat.
module keypad_encoder_db
    import keypad_pkg::*;
#(
    parameter int unsigned N_KEYS          = 10,
    parameter int unsigned DW              = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] keypad,
    input  logic              enablen,
    output logic [DW-1:0]     D,
    output logic              loadn,
    output logic              key_held,
    output logic              multi_key
);

    localparam int unsigned CW      = clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RW_RAW  = clog2(REPEAT_CYCLES + 1);
    localparam int unsigned RW      = (RW_RAW < 1) ? 1 : RW_RAW;
    localparam int unsigned CNT_L_I = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam int unsigned REP_L_I = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    // cnt starts at 1 on the capturing sample, so the final accepted sample
    // is the one seen while cnt already holds DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_L_I);
    localparam logic [RW-1:0] REP_LAST = RW'(REP_L_I);

    logic [N_KEYS-1:0] s;
    logic [N_KEYS-1:0] snap;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     rep;
    logic [CW-1:0]     cnt_inc;
    logic [RW-1:0]     rep_inc;

    sync2 #(
        .W(N_KEYS)
    ) u_sync (
        .clk   (clk),
        .resetn(resetn),
        .d     (keypad),
        .q     (s)
    );

    // Saturating increments so neither counter can wrap.
    always_comb begin
        cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
        rep_inc = (rep == '1) ? rep : rep + RW'(1);
    end

    // Keypad FSM with counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            snap      <= '0;
            cnt       <= '0;
            rep       <= '0;
            D         <= '0;
            loadn     <= 1'b1;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            loadn <= 1'b1;
            if (enablen) begin
                state    <= IDLE;
                cnt      <= '0;
                rep      <= '0;
                key_held <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (s != '0) begin
                            snap  <= s;
                            cnt   <= CNT_ONE;
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (s == '0) begin
                            state <= IDLE;
                        end else if (s == snap) begin
                            cnt <= cnt_inc;
                            if (cnt >= CNT_LAST) begin
                                state <= PRESS;
                            end
                        end else begin
                            snap <= s;
                            cnt  <= CNT_ONE;
                        end
                    end
                    PRESS: begin
                        loadn     <= 1'b0;
                        D         <= DW'(prio_encode(MAX_KEYS'(snap), N_KEYS));
                        multi_key <= multi_hot(MAX_KEYS'(snap));
                        key_held  <= 1'b1;
                        rep       <= '0;
                        state     <= HOLD;
                    end
                    HOLD: begin
                        if (s == '0) begin
                            cnt   <= CNT_ONE;
                            state <= RELEASE;
                        end else if (REPEAT_CYCLES > 0) begin
                            rep <= rep_inc;
                            if (rep >= REP_LAST) begin
                                state <= PRESS;
                            end
                        end
                    end
                    RELEASE: begin
                        if (s != '0) begin
                            rep   <= '0;
                            state <= HOLD;
                        end else if (cnt >= CNT_LAST) begin
                            key_held <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_encoder_db.sv
// Scoreboard bench: stimulus pushes expected strobes, monitors pop and compare.
module tb_keypad_encoder_db;

    typedef struct {
        int d;
        int m;
        int cyc;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic       enablen;
    logic [9:0] keypad;
    logic [9:0] keypad2;
    logic [3:0] D0, D1;
    logic       loadn0, loadn1;
    logic       held0, held1;
    logic       multi0, multi1;

    int   cyc;
    int   checks;
    int   failures;
    exp_t q0[$];
    exp_t q1[$];

    keypad_encoder_db #(
        .N_KEYS(10), .DW(4), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)
    ) dut0 (
        .clk(clk), .resetn(resetn), .keypad(keypad), .enablen(enablen),
        .D(D0), .loadn(loadn0), .key_held(held0), .multi_key(multi0)
    );

    keypad_encoder_db #(
        .N_KEYS(10), .DW(4), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)
    ) dut1 (
        .clk(clk), .resetn(resetn), .keypad(keypad2), .enablen(enablen),
        .D(D1), .loadn(loadn1), .key_held(held1), .multi_key(multi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int which, input int d, input int m, input int c);
        exp_t e;
        e.d = d;
        e.m = m;
        e.cyc = c;
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor for the non-repeating instance.
    always @(negedge clk) begin
        exp_t e;
        if (loadn0 === 1'b0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_strobe_D", int'(D0), -1);
            end else begin
                e = q0.pop_front();
                chk("dut0_strobe_cycle", cyc, e.cyc);
                chk("dut0_strobe_D", int'(D0), e.d);
                chk("dut0_strobe_multi", int'(multi0), e.m);
                chk("dut0_strobe_held", int'(held0), 1);
            end
        end
    end

    // Monitor for the auto-repeat instance.
    always @(negedge clk) begin
        exp_t e;
        if (loadn1 === 1'b0) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_strobe_D", int'(D1), -1);
            end else begin
                e = q1.pop_front();
                chk("dut1_strobe_cycle", cyc, e.cyc);
                chk("dut1_strobe_D", int'(D1), e.d);
                chk("dut1_strobe_multi", int'(multi1), e.m);
            end
        end
    end

    initial begin
        int c;
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        enablen  = 1'b0;
        keypad   = '0;
        keypad2  = '0;
        ticks(3);
        chk("reset_D", int'(D0), 0);
        chk("reset_loadn", int'(loadn0), 1);
        chk("reset_held", int'(held0), 0);
        chk("reset_multi", int'(multi0), 0);
        resetn = 1'b1;
        ticks(3);

        // Key 3 held, then released; key_held falls 6 edges after release.
        c = cyc;
        keypad = 10'b0000001000;
        push(0, 3, 0, c + 7);
        ticks(20);
        chk("k3_held_during", int'(held0), 1);
        c = cyc;
        keypad = '0;
        ticks(5);
        chk("k3_held_before_fall", int'(held0), 1);
        ticks(1);
        chk("k3_held_after_fall", int'(held0), 0);
        chk("k3_D_retained", int'(D0), 3);
        ticks(4);

        // Key 6 bounces for 6 cycles, then settles.
        for (int i = 0; i < 6; i++) begin
            keypad = (i % 2 == 0) ? 10'b0001000000 : 10'b0000000000;
            ticks(1);
        end
        c = cyc;
        keypad = 10'b0001000000;
        push(0, 6, 0, c + 7);
        ticks(12);
        keypad = '0;
        ticks(10);

        // Keys 9 and 2 together, then switch to key 1 while held.
        c = cyc;
        keypad = 10'b1000000100;
        push(0, 9, 1, c + 7);
        ticks(12);
        keypad = 10'b0000000010;
        ticks(12);
        chk("multi_D_stays", int'(D0), 9);
        chk("multi_flag_stays", int'(multi0), 1);
        chk("multi_held", int'(held0), 1);
        keypad = '0;
        ticks(10);
        chk("multi_released", int'(held0), 0);

        // Auto-repeat: strobe every 9 cycles while key 5 is held.
        c = cyc;
        keypad2 = 10'b0000100000;
        push(1, 5, 0, c + 7);
        push(1, 5, 0, c + 16);
        push(1, 5, 0, c + 25);
        push(1, 5, 0, c + 34);
        ticks(36);
        keypad2 = '0;
        ticks(12);
        chk("repeat_released", int'(held1), 0);

        // Disabled keypad accepts nothing; enabling starts a fresh debounce.
        enablen = 1'b1;
        keypad  = 10'b0000010000;
        ticks(15);
        chk("disabled_held", int'(held0), 0);
        chk("disabled_D_kept", int'(D0), 9);
        c = cyc;
        enablen = 1'b0;
        push(0, 4, 0, c + 5);
        ticks(10);
        chk("enable_D", int'(D0), 4);
        keypad = '0;
        ticks(10);

        // Reset during debounce of key 7.
        keypad = 10'b0010000000;
        ticks(3);
        resetn = 1'b0;
        #1;
        chk("midreset_D", int'(D0), 0);
        chk("midreset_loadn", int'(loadn0), 1);
        chk("midreset_held", int'(held0), 0);
        ticks(2);
        c = cyc;
        resetn = 1'b1;
        push(0, 7, 0, c + 7);
        ticks(12);
        keypad = '0;
        ticks(10);

        chk("dut0_pending_strobes", q0.size(), 0);
        chk("dut1_pending_strobes", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_encoder_db.md
Name: keypad_encoder_db

Overview:
- Parametrised, clocked successor to the combinational keypad encoder in the microwave front panel.
- Synchronises and debounces an N-key one-hot keypad, then priority-encodes the pressed key onto D.
- Emits a single-cycle active-low load strobe per press, with optional auto-repeat while a key is held.
- Feeds the digit-entry register and timer loader downstream, which consume D on loadn low.

Parameters:
- N_KEYS, 10, number of keypad lines; key index i encodes as value i.
- DW, 4, width of D; must satisfy 2^DW >= N_KEYS.
- DEBOUNCE_CYCLES, 4, number of consecutive identical samples required for press and release; minimum 1.
- REPEAT_CYCLES, 0, hold cycles between auto-repeat strobes; 0 disables repeat.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- keypad  in  N_KEYS  raw key lines, active-high, asynchronous to clk.
- enablen  in  1  active-low enable; high suppresses all key acceptance.
- D  out  DW  encoded key value, registered.
- loadn  out  1  active-low one-cycle load strobe, registered.
- key_held  out  1  high from the strobe until release is debounced.
- multi_key  out  1  high when the accepted snapshot had more than one bit set.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (resetn).
- Reset values: D=0, loadn=1, key_held=0, multi_key=0, state=IDLE, all counters 0, synchroniser flops 0.
- Synchroniser: two-flop, per bit. s denotes the synchronised vector.
- Encoding: highest set index in the snapshot wins. D is zero-extended to DW. multi_key=1 iff popcount(snapshot)>1.
- States:
  - IDLE: if enablen=0 and s!=0: capture snap=s, cnt=1, go DEBOUNCE.
  - DEBOUNCE: if s==snap: cnt++; when cnt reaches DEBOUNCE_CYCLES go PRESS. If s==0: go IDLE. If s is another nonzero value: snap=s, cnt=1.
  - PRESS (exactly one cycle): loadn=0; D and multi_key updated from snap; key_held=1; rep=0; go HOLD.
  - HOLD: if s==0: cnt=1, go RELEASE. Other nonzero s is ignored; D is unchanged and no strobe is issued. If REPEAT_CYCLES>0: rep++; at rep==REPEAT_CYCLES go PRESS with the same snap.
  - RELEASE: if s!=0: go HOLD, rep reset to 0. If s==0 for DEBOUNCE_CYCLES consecutive samples: key_held=0, go IDLE.
- Latency: with keypad stable from edge k, loadn is low in the cycle after edge k+DEBOUNCE_CYCLES+2. For DEBOUNCE_CYCLES=4, loadn falls after edge k+6 and is low for one cycle.
- D holds its last value after the strobe until the next PRESS. D is never cleared on release.
- enablen=1 in any state: go IDLE on the next edge; loadn forced to 1; key_held=0. D and multi_key retain their values.
- DEBOUNCE_CYCLES=1: press is accepted on the first sample matching the captured snapshot.
- Counters: cnt width = clog2(DEBOUNCE_CYCLES+1). rep width = clog2(REPEAT_CYCLES+1), minimum 1. Counters saturate and never wrap.
- resetn asserted mid-press: immediate return to reset values; no strobe is generated on deassertion.

Decomposition:
- Package keypad_pkg:
  - state enum {IDLE, DEBOUNCE, PRESS, HOLD, RELEASE}.
  - clog2 function.
  - priority-encode function (highest-index, parametrised by N_KEYS and DW).
  - popcount>1 function.
- Sub-module sync2 (width-parametrised two-flop synchroniser with async active-low reset), instantiated once on keypad.
- The FSM, counters and output registers live in the top module.

Test Plan:
- Defaults; key 3 (keypad=10'b0000001000) held 20 cycles, then released -> exactly one loadn pulse, D=3, multi_key=0, key_held falls DEBOUNCE_CYCLES+2 cycles after release.
- Bounce on key 6: bit toggles every cycle for 6 cycles, then stable -> no strobe during toggling; one strobe with D=6, timed from the first stable edge.
- Keys 9 and 2 together (10'b1000000100) -> D=9, multi_key=1; while held, switching to key 1 only -> no new strobe, D stays 9.
- REPEAT_CYCLES=8; key 5 held 40 cycles -> initial strobe plus strobes every 9 cycles (PRESS + 8 HOLD), all with D=5.
- enablen=1 while key 4 is pressed -> no strobe. Dropping enablen with key 4 still held -> new debounce, one strobe with D=4.
- resetn pulsed low during DEBOUNCE of key 7 -> D=0, loadn=1 immediately. After release of resetn with key still held -> strobe occurs one full synchroniser and debounce latency later.
